// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter.
// Contents: default address/block widths, FSM state encoding and the
// encoding used to remember which requester was served last.
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 28;
  localparam int BLOCK_W_DEF = 128;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_REQ  = 3'd1,
    I_WAIT = 3'd2,
    D_REQ  = 3'd3,
    D_WAIT = 3'd4
  } arb_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

endpackage

// File: rtl/memory_arbiter_arb_select.sv
// Grant choice between the instruction and data requesters.
// Ports:
//   i_req, d_req  in  raw requests (d_req = d_read | d_write)
//   i_ack, d_ack  in  one-cycle acks; an acked requester is not eligible
//   last_grant    in  requester served by the most recent completion
//   grant_valid   out at least one eligible requester
//   grant         out chosen requester (meaningful when grant_valid)
module arb_select
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  logic   i_ack,
  input  logic   d_ack,
  input  grant_e last_grant,
  output logic   grant_valid,
  output grant_e grant
);

  logic i_pend_s;
  logic d_pend_s;

  // Eligibility masks and priority: data wins a tie unless it was served last.
  always_comb begin
    i_pend_s    = i_req & ~i_ack;
    d_pend_s    = d_req & ~d_ack;
    grant_valid = i_pend_s | d_pend_s;
    if (i_pend_s && d_pend_s) begin
      grant = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
    end else if (d_pend_s) begin
      grant = GRANT_D;
    end else begin
      grant = GRANT_I;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates an instruction cache and a data cache onto one block-wide
// main-memory port. One transfer at a time; every memory-side output and
// every readdata output is a register.
// Ports:
//   CLK, RESET                         clock, async active-low reset
//   i_read, i_address                  instruction block read request
//   i_readdata, i_busywait             returned block, instruction stall
//   d_read, d_write, d_address,
//   d_writedata                        data read / write-back request
//   d_readdata, d_busywait             returned block, data stall
//   mem_read, mem_write, mem_address,
//   mem_writedata                      shared memory request (registered)
//   mem_readdata, mem_busywait         memory response
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int BLOCK_W = BLOCK_W_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               i_read,
  input  logic [ADDR_W-1:0]  i_address,
  output logic [BLOCK_W-1:0] i_readdata,
  output logic               i_busywait,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_address,
  input  logic [BLOCK_W-1:0] d_writedata,
  output logic [BLOCK_W-1:0] d_readdata,
  output logic               d_busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait
);

  arb_state_e         state_r,        state_nxt_s;
  grant_e             last_grant_r,   last_grant_nxt_s;
  logic               i_ack_r,        i_ack_nxt_s;
  logic               d_ack_r,        d_ack_nxt_s;
  logic               mem_read_nxt_s, mem_write_nxt_s;
  logic [ADDR_W-1:0]  mem_address_nxt_s;
  logic [BLOCK_W-1:0] mem_writedata_nxt_s;
  logic [BLOCK_W-1:0] i_readdata_nxt_s, d_readdata_nxt_s;
  logic               d_req_s;
  logic               grant_valid_s;
  grant_e             grant_s;

  assign d_req_s = d_read | d_write;

  // Stall while a request is held and has not yet been acknowledged.
  assign i_busywait = i_read & ~i_ack_r;
  assign d_busywait = d_req_s & ~d_ack_r;

  arb_select u_arb_select (
    .i_req       (i_read),
    .d_req       (d_req_s),
    .i_ack       (i_ack_r),
    .d_ack       (d_ack_r),
    .last_grant  (last_grant_r),
    .grant_valid (grant_valid_s),
    .grant       (grant_s)
  );

  // Next-state and next-register values; everything holds unless changed.
  always_comb begin
    state_nxt_s         = state_r;
    last_grant_nxt_s    = last_grant_r;
    i_ack_nxt_s         = 1'b0;
    d_ack_nxt_s         = 1'b0;
    mem_read_nxt_s      = mem_read;
    mem_write_nxt_s     = mem_write;
    mem_address_nxt_s   = mem_address;
    mem_writedata_nxt_s = mem_writedata;
    i_readdata_nxt_s    = i_readdata;
    d_readdata_nxt_s    = d_readdata;
    case (state_r)
      IDLE: begin
        if (grant_valid_s && (grant_s == GRANT_D)) begin
          state_nxt_s         = D_REQ;
          mem_address_nxt_s   = d_address;
          mem_writedata_nxt_s = d_writedata;
          // read+write together is a write-back
          mem_write_nxt_s     = d_write;
          mem_read_nxt_s      = ~d_write;
        end else if (grant_valid_s) begin
          state_nxt_s       = I_REQ;
          mem_address_nxt_s = i_address;
          mem_write_nxt_s   = 1'b0;
          mem_read_nxt_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      // Memory raises busywait on the cycle it first sees the strobe; skip it.
      I_REQ: state_nxt_s = I_WAIT;
      D_REQ: state_nxt_s = D_WAIT;
      I_WAIT: begin
        if (!mem_busywait) begin
          state_nxt_s      = IDLE;
          mem_read_nxt_s   = 1'b0;
          mem_write_nxt_s  = 1'b0;
          i_readdata_nxt_s = mem_readdata;
          i_ack_nxt_s      = 1'b1;
          last_grant_nxt_s = GRANT_I;
        end else begin
          state_nxt_s = I_WAIT;
        end
      end
      D_WAIT: begin
        if (!mem_busywait) begin
          state_nxt_s      = IDLE;
          mem_read_nxt_s   = 1'b0;
          mem_write_nxt_s  = 1'b0;
          d_ack_nxt_s      = 1'b1;
          last_grant_nxt_s = GRANT_D;
          // write-back completions leave d_readdata untouched
          if (mem_read) begin
            d_readdata_nxt_s = mem_readdata;
          end else begin
            d_readdata_nxt_s = d_readdata;
          end
        end else begin
          state_nxt_s = D_WAIT;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        mem_read_nxt_s  = 1'b0;
        mem_write_nxt_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r       <= IDLE;
      last_grant_r  <= GRANT_I;
      i_ack_r       <= 1'b0;
      d_ack_r       <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= {ADDR_W{1'b0}};
      mem_writedata <= {BLOCK_W{1'b0}};
      i_readdata    <= {BLOCK_W{1'b0}};
      d_readdata    <= {BLOCK_W{1'b0}};
    end else begin
      state_r       <= state_nxt_s;
      last_grant_r  <= last_grant_nxt_s;
      i_ack_r       <= i_ack_nxt_s;
      d_ack_r       <= d_ack_nxt_s;
      mem_read      <= mem_read_nxt_s;
      mem_write     <= mem_write_nxt_s;
      mem_address   <= mem_address_nxt_s;
      mem_writedata <= mem_writedata_nxt_s;
      i_readdata    <= i_readdata_nxt_s;
      d_readdata    <= d_readdata_nxt_s;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios followed by
// randomized traffic, all checked cycle by cycle against a transaction-level
// reference model of the arbiter and a small wait-state memory model.
module tb_memory_arbiter;

  logic         CLK;
  logic         RESET;
  logic         i_read;
  logic [27:0]  i_address;
  logic [127:0] i_readdata;
  logic         i_busywait;
  logic         d_read, d_write;
  logic [27:0]  d_address;
  logic [127:0] d_writedata;
  logic [127:0] d_readdata;
  logic         d_busywait;
  logic         mem_read, mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  memory_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- memory model ----------------
  bit           fixed_en   = 1'b0;
  logic [127:0] fixed_data = 128'd0;
  int           cur_w      = 0;
  int unsigned  hi_cnt;

  function automatic logic [127:0] blk(input logic [27:0] a);
    logic [31:0] w;
    w = {4'hC, a} ^ 32'h9E3779B9;
    return {w, ~w, w ^ 32'h5555AAAA, {a, 4'h3}};
  endfunction

  function automatic logic [127:0] mem_data(input logic [27:0] a);
    return fixed_en ? fixed_data : blk(a);
  endfunction

  // cycles the memory has seen the current strobe (0 on its first cycle)
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) hi_cnt <= 0;
    else if (mem_read || mem_write) hi_cnt <= hi_cnt + 1;
    else hi_cnt <= 0;
  end

  assign mem_busywait = (mem_read || mem_write) && (hi_cnt <= cur_w);
  assign mem_readdata = mem_data(mem_address);

  // ---------------- reference model ----------------
  logic         e_mem_read, e_mem_write, e_i_ack, e_d_ack;
  logic [27:0]  e_addr;
  logic [127:0] e_wdata, e_i_data, e_d_data;
  bit           m_busy, m_who, m_phase, m_last;   // who/last: 1 = data
  int           m_wcnt;
  int           force_w = -1;

  task automatic model_reset();
    e_mem_read = 1'b0; e_mem_write = 1'b0; e_i_ack = 1'b0; e_d_ack = 1'b0;
    e_addr = 28'd0; e_wdata = 128'd0; e_i_data = 128'd0; e_d_data = 128'd0;
    m_busy = 1'b0; m_who = 1'b0; m_phase = 1'b0; m_last = 1'b0; m_wcnt = 0;
  endtask

  // Predict the effect of the coming rising edge from current inputs.
  task automatic predict();
    bit ip, dp;
    ip = i_read && !e_i_ack;
    dp = (d_read || d_write) && !e_d_ack;
    e_i_ack = 1'b0;
    e_d_ack = 1'b0;
    if (!m_busy) begin
      if (ip || dp) begin
        m_who   = (ip && dp) ? !m_last : dp;
        m_busy  = 1'b1;
        m_phase = 1'b0;
        cur_w   = (force_w < 0) ? int'($urandom_range(3)) : force_w;
        if (m_who) begin
          e_addr = d_address; e_wdata = d_writedata;
          e_mem_write = d_write; e_mem_read = !d_write;
        end else begin
          e_addr = i_address; e_mem_read = 1'b1; e_mem_write = 1'b0;
        end
      end
    end else if (!m_phase) begin
      m_phase = 1'b1;
      m_wcnt  = 1;
    end else if (m_wcnt > cur_w) begin
      if (e_mem_read && m_who) e_d_data = mem_data(e_addr);
      else if (e_mem_read) e_i_data = mem_data(e_addr);
      e_mem_read = 1'b0; e_mem_write = 1'b0;
      m_busy = 1'b0; m_last = m_who;
      if (m_who) e_d_ack = 1'b1; else e_i_ack = 1'b1;
    end else begin
      m_wcnt++;
    end
  endtask

  // ---------------- requesters ----------------
  int i_rate = 0, d_rate = 0, reissue = 0, d_wr_pct = 40;

  task automatic new_i();
    i_read = 1'b1;
    i_address = {1'b0, 27'($urandom)};
  endtask

  task automatic new_d();
    bit wr;
    wr = ($urandom_range(99) < d_wr_pct);
    d_write = wr;
    d_read = !wr || ($urandom_range(3) == 0);
    d_address = {1'b1, 27'($urandom)};
    d_writedata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic policy();
    if (e_i_ack) begin
      if ($urandom_range(99) < reissue) new_i(); else i_read = 1'b0;
    end else if (!i_read && $urandom_range(99) < i_rate) begin
      new_i();
    end
    if (e_d_ack) begin
      if ($urandom_range(99) < reissue) new_d(); else begin d_read = 1'b0; d_write = 1'b0; end
    end else if (!d_read && !d_write && $urandom_range(99) < d_rate) begin
      new_d();
    end
  endtask

  // ---------------- per-cycle step ----------------
  int step_no = 0, cnt_rd = 0, cnt_wr = 0, cnt_ilo = 0;
  logic [27:0] rise_addr[$];
  int          rise_step[$];

  task automatic check_all();
    check_val("mem_read",      128'(mem_read),      128'(e_mem_read));
    check_val("mem_write",     128'(mem_write),     128'(e_mem_write));
    check_val("mem_address",   128'(mem_address),   128'(e_addr));
    check_val("mem_writedata", mem_writedata,       e_wdata);
    check_val("i_readdata",    i_readdata,          e_i_data);
    check_val("d_readdata",    d_readdata,          e_d_data);
    check_val("i_busywait",    128'(i_busywait),    128'(i_read && !e_i_ack));
    check_val("d_busywait",    128'(d_busywait),    128'((d_read || d_write) && !e_d_ack));
  endtask

  task automatic step();
    logic prev_stb;
    prev_stb = mem_read | mem_write;
    predict();
    @(negedge CLK);
    step_no++;
    check_all();
    if (mem_read) cnt_rd++;
    if (mem_write) cnt_wr++;
    if (i_read && !i_busywait) cnt_ilo++;
    if (!prev_stb && (mem_read || mem_write)) begin
      rise_addr.push_back(mem_address);
      rise_step.push_back(step_no);
    end
    policy();
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    i_rate = 0; d_rate = 0; reissue = 0;
    while (k < 100 && (m_busy || i_read || d_read || d_write || e_i_ack || e_d_ack)) begin
      step();
      k++;
    end
    check_val(tag, 128'(k < 100), 128'(1));
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [27:0]  ia, da;
    logic [127:0] saved;
    int lo_at;

    RESET = 1'b0;
    i_read = 1'b0; i_address = 28'd0;
    d_read = 1'b0; d_write = 1'b0; d_address = 28'd0; d_writedata = 128'd0;
    model_reset();
    #3;
    check_all();
    check_val("rst_mem_addr", 128'(mem_address), 128'd0);
    @(negedge CLK);
    RESET = 1'b1;

    // single instruction read, two memory wait cycles
    fixed_en = 1'b1; fixed_data = {8{16'hAAAA}}; force_w = 2;
    cnt_rd = 0; cnt_ilo = 0;
    i_read = 1'b1; i_address = 28'h0000010;
    for (int k = 0; k < 12; k++) step();
    check_val("rd_cycles_034", 128'(cnt_rd), 128'd4);
    check_val("ilo_cycles_034", 128'(cnt_ilo), 128'd1);
    check_val("i_rdata_034", i_readdata, {8{16'hAAAA}});
    fixed_en = 1'b0;

    // zero-wait read latency
    force_w = 0; cnt_ilo = 0; lo_at = 0;
    new_i();
    for (int k = 1; k <= 6; k++) begin
      step();
      if (cnt_ilo != 0 && lo_at == 0) lo_at = k;
    end
    check_val("latency_039", 128'(lo_at), 128'd3);

    // simultaneous requests after an instruction grant: data first
    rise_addr.delete(); rise_step.delete();
    ia = {1'b0, 27'($urandom)}; da = {1'b1, 27'($urandom)};
    i_read = 1'b1; i_address = ia; d_read = 1'b1; d_write = 1'b0; d_address = da;
    for (int k = 0; k < 10; k++) step();
    check_val("grants_035", 128'(rise_addr.size()), 128'd2);
    if (rise_addr.size() >= 2) begin
      check_val("first_addr_035", 128'(rise_addr[0]), 128'(da));
      check_val("second_addr_035", 128'(rise_addr[1]), 128'(ia));
      check_val("gap_035", 128'(rise_step[1] - rise_step[0]), 128'd3);
    end

    // continuous re-requests alternate D, I, D, I
    force_w = -1;
    rise_addr.delete(); rise_step.delete();
    i_rate = 100; d_rate = 100; reissue = 100;
    for (int k = 0; k < 80 && rise_addr.size() < 4; k++) step();
    check_val("grants_036", 128'(rise_addr.size() >= 4), 128'(1));
    for (int k = 0; k < 4 && k < rise_addr.size(); k++)
      check_val("order_036", 128'(rise_addr[k][27]), 128'(k % 2 == 0));
    drain("drain_036");

    // write-back leaves d_readdata alone
    force_w = 1; cnt_wr = 0;
    saved = e_d_data;
    d_read = 1'b0; d_write = 1'b1; d_address = {1'b1, 27'h0000ABC};
    d_writedata = {8{16'h1234}};
    for (int k = 0; k < 8; k++) step();
    check_val("wr_cycles_037", 128'(cnt_wr), 128'd3);
    check_val("wdata_037", mem_writedata, {8{16'h1234}});
    check_val("d_rdata_037", d_readdata, saved);

    // reset in the middle of a data read
    force_w = 3;
    da = {1'b1, 27'h1234567};
    d_read = 1'b1; d_write = 1'b0; d_address = da;
    step(); step();
    check_val("in_wait_038", 128'(m_busy && m_phase), 128'(1));
    #2 RESET = 1'b0;
    #1;
    check_val("rst_mem_read_038", 128'(mem_read), 128'd0);
    check_val("rst_d_busy_038", 128'(d_busywait), 128'd1);
    check_val("rst_d_rdata_038", d_readdata, 128'd0);
    model_reset();
    @(negedge CLK);
    check_all();
    RESET = 1'b1;
    rise_addr.delete(); rise_step.delete();
    for (int k = 0; k < 8; k++) step();
    check_val("reissue_038", 128'(rise_addr.size()), 128'd1);
    if (rise_addr.size() >= 1) check_val("reissue_addr_038", 128'(rise_addr[0]), 128'(da));
    drain("drain_038");

    // randomized traffic
    force_w = -1; i_rate = 30; d_rate = 30; reissue = 50; d_wr_pct = 40;
    for (int k = 0; k < 600; k++) step();
    drain("drain_rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 28, block address width; BLOCK_W, default 128, cache-block data width.
REQ-002 CLK  in  1  single clock; all state updates on the rising edge.
REQ-003 RESET  in  1  asynchronous, active-low reset.
REQ-004 i_read  in  1  instruction-cache block read request, held until acknowledged.
REQ-005 i_address  in  ADDR_W  instruction block address.
REQ-006 i_readdata  out  BLOCK_W  instruction block returned.
REQ-007 i_busywait  out  1  instruction requester stalled.
REQ-008 d_read, d_write  in  1 each  data-cache block read / write-back requests, held until acknowledged.
REQ-009 d_address  in  ADDR_W; d_writedata  in  BLOCK_W  data block address and write-back data.
REQ-010 d_readdata  out  BLOCK_W; d_busywait  out  1  data block returned; data requester stalled.
REQ-011 mem_read, mem_write  out  1; mem_address  out  ADDR_W; mem_writedata  out  BLOCK_W  shared main-memory port.
REQ-012 mem_readdata  in  BLOCK_W; mem_busywait  in  1  memory response; memory asserts busywait in the same cycle it first sees a request.

Function
REQ-013 FSM states: IDLE, I_REQ, I_WAIT, D_REQ, D_WAIT.
REQ-014 IDLE: grant is chosen from pending requests, excluding any requester acknowledged in this cycle; no pending request -> stay in IDLE.
REQ-015 Only one requester pending -> grant it.
REQ-016 Both pending -> grant data, unless the last completed grant was data, then grant instruction (no starvation).
REQ-017 On the grant edge, mem_address, mem_read/mem_write and mem_writedata are registered from the granted requester; next state is *_REQ.
REQ-018 *_REQ lasts exactly one cycle; mem_busywait is ignored; next state is *_WAIT.
REQ-019 *_WAIT: if mem_busywait=1, hold; if mem_busywait=0, complete.
REQ-020 Completion edge: clear mem_read/mem_write; capture mem_readdata into i_readdata or d_readdata (reads only); set a one-cycle ack for the served requester; record the last grant; next state is IDLE.
REQ-021 i_busywait = i_read AND NOT i_ack; d_busywait = (d_read OR d_write) AND NOT d_ack; i_busywait and d_busywait are combinational outputs.
REQ-022 Requester drops its request at the edge where its busywait is sampled low.
REQ-023 Minimum latency: request visible at edge t -> mem strobe high from t+1 -> busywait low in cycle t+3 when memory responds with zero wait.
REQ-024 d_read and d_write both high: treated as a write.
REQ-025 On a write completion, d_readdata is unchanged.
REQ-026 Request inputs changing while a grant is active are ignored until IDLE.
REQ-027 mem_address and mem_writedata hold their value while no request is active.
REQ-028 readdata outputs hold their value until the next read completion.

Reset
REQ-029 RESET low, asynchronously: state IDLE; mem_read=0, mem_write=0; mem_address=0, mem_writedata=0; i_readdata=0, d_readdata=0; acks=0; last grant=instruction.
REQ-030 Reset during *_REQ or *_WAIT aborts the transfer and returns no data; busywait reflects the raw request.
REQ-031 First grant is evaluated at the first rising edge after RESET goes high.

Structure
REQ-032 Package mem_arb_pkg: state enumeration, ADDR_W/BLOCK_W defaults, last-grant encoding.
REQ-033 One sub-module, arb_select: combinational grant choice from the two requests, ack masks and last grant.

Verification
REQ-034 i_read=1, i_address=0x0000010, memory has 2 wait cycles returning 0xAAAA...: mem_read high for 4 cycles; i_readdata=0xAAAA...; i_busywait low exactly one cycle.
REQ-035 i_read and d_read raised on the same edge, last grant=instruction: data is served first, then instruction; mem_address order is d then i; no idle gap beyond the ack cycle.
REQ-036 Both requesters continuously re-request for 4 transfers: grants alternate D, I, D, I.
REQ-037 d_write=1, d_writedata=0x1234...: mem_write=1 with mem_writedata=0x1234...; d_readdata is unchanged after completion.
REQ-038 RESET pulled low mid-D_WAIT: mem_read=0 immediately (no clock edge); state IDLE; d_busywait=1 while d_read is held; transfer is reissued after reset release.
REQ-039 Zero-wait memory: single i_read completes with busywait low in cycle t+3.
